// File: rtl/sap_1_controller_sequencer.sv
// -----------------------------------------------------------------------------
// sap_1_controller_sequencer
//
// Purpose: SAP-1 controller/sequencer. A six-state one-hot ring counter
// (T1..T6) steps through fetch (T1-T3) and execute (T4-T6). The 12-bit
// control word is decoded combinationally from the ring state, the halt
// flag and the decoded opcode lines. Executing HLT freezes the ring at T4
// until reset.
//
// Ports:
//   clk      in   1   rising-edge clock
//   rst_n    in   1   asynchronous active-low reset
//   LDA      in   1   decoded opcode 0000
//   ADD      in   1   decoded opcode 0001
//   SUB      in   1   decoded opcode 0010
//   OUT      in   1   decoded opcode 1110
//   HLT      in   1   decoded opcode 1111
//   t_state  out  6   one-hot ring state, bit0 = T1 ... bit5 = T6
//   con      out  12  {Cp, Ep, Lm_n, CE_n, Li_n, Ei_n, La_n, Ea, Su, Eu, Lb_n, Lo_n}
//   halted   out  1   set once HLT has executed
// -----------------------------------------------------------------------------
module sap_1_controller_sequencer (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        LDA,
    input  logic        ADD,
    input  logic        SUB,
    input  logic        OUT,
    input  logic        HLT,
    output logic [5:0]  t_state,
    output logic [11:0] con,
    output logic        halted
);

    typedef enum logic [5:0] {
        StT1 = 6'b000001,
        StT2 = 6'b000010,
        StT3 = 6'b000100,
        StT4 = 6'b001000,
        StT5 = 6'b010000,
        StT6 = 6'b100000
    } tstate_e;

    typedef enum logic [2:0] {
        OpNop,
        OpLda,
        OpAdd,
        OpSub,
        OpOut,
        OpHlt
    } op_e;

    // Control words, all active-low strobes deasserted in ConIdle.
    localparam logic [11:0] ConIdle   = 12'h3E3;
    localparam logic [11:0] ConFetch1 = 12'h5E3;  // Ep, Lm_n
    localparam logic [11:0] ConFetch2 = 12'hBE3;  // Cp
    localparam logic [11:0] ConFetch3 = 12'h263;  // CE_n, Li_n
    localparam logic [11:0] ConAddrIr = 12'h1A3;  // Ei_n, Lm_n
    localparam logic [11:0] ConLdaT5  = 12'h2C3;  // CE_n, La_n
    localparam logic [11:0] ConLoadB  = 12'h2E1;  // CE_n, Lb_n
    localparam logic [11:0] ConAddT6  = 12'h3C7;  // Eu, La_n
    localparam logic [11:0] ConSubT6  = 12'h3CF;  // Su, Eu, La_n
    localparam logic [11:0] ConOutT4  = 12'h3F2;  // Ea, Lo_n

    tstate_e     r_t_state;
    logic        r_halted;
    op_e         w_op;
    logic [11:0] w_con;

    // Opcode priority resolution: HLT > OUT > SUB > ADD > LDA.
    always_comb begin
        w_op = OpNop;
        if (HLT)      w_op = OpHlt;
        else if (OUT) w_op = OpOut;
        else if (SUB) w_op = OpSub;
        else if (ADD) w_op = OpAdd;
        else if (LDA) w_op = OpLda;
    end

    // Ring counter and halt flag. Any non-one-hot state falls into the
    // default arm and recovers to T1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_t_state <= StT1;
            r_halted  <= 1'b0;
        end else if (!r_halted) begin
            case (r_t_state)
                StT1: r_t_state <= StT2;
                StT2: r_t_state <= StT3;
                StT3: r_t_state <= StT4;
                StT4: begin
                    if (w_op == OpHlt) r_halted  <= 1'b1;  // ring stays at T4
                    else               r_t_state <= StT5;
                end
                StT5: r_t_state <= StT6;
                StT6: r_t_state <= StT1;
                default: r_t_state <= StT1;
            endcase
        end
    end

    // Control word decode. Reset is folded in so con is idle for the whole
    // reset pulse, not just after the flops settle.
    always_comb begin
        w_con = ConIdle;
        if (rst_n && !r_halted) begin
            case (r_t_state)
                StT1: w_con = ConFetch1;
                StT2: w_con = ConFetch2;
                StT3: w_con = ConFetch3;
                StT4: begin
                    case (w_op)
                        OpLda, OpAdd, OpSub: w_con = ConAddrIr;
                        OpOut:               w_con = ConOutT4;
                        default:             w_con = ConIdle;
                    endcase
                end
                StT5: begin
                    case (w_op)
                        OpLda:        w_con = ConLdaT5;
                        OpAdd, OpSub: w_con = ConLoadB;
                        default:      w_con = ConIdle;
                    endcase
                end
                StT6: begin
                    case (w_op)
                        OpAdd:   w_con = ConAddT6;
                        OpSub:   w_con = ConSubT6;
                        default: w_con = ConIdle;
                    endcase
                end
                default: w_con = ConIdle;
            endcase
        end
    end

    assign t_state = r_t_state;
    assign halted  = r_halted;
    assign con     = w_con;

endmodule

// File: tb/tb_sap_1_controller_sequencer.sv
// -----------------------------------------------------------------------------
// tb_sap_1_controller_sequencer
//
// Purpose: self-checking bench for sap_1_controller_sequencer. A table of
// per-cycle vectors covers each instruction's full six-state sequence; hand
// sequences cover halt, asynchronous reset mid-instruction and reset release
// coincident with a clock edge.
// -----------------------------------------------------------------------------
module tb_sap_1_controller_sequencer;

    localparam logic [4:0] OpL = 5'b00001;
    localparam logic [4:0] OpA = 5'b00010;
    localparam logic [4:0] OpS = 5'b00100;
    localparam logic [4:0] OpO = 5'b01000;
    localparam logic [4:0] OpH = 5'b10000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [4:0]  op;
    logic [5:0]  t_state;
    logic [11:0] con;
    logic        halted;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        string       name;
        logic [4:0]  op;
        logic [5:0]  t;
        logic [11:0] c;
        logic        h;
    } vec_t;

    vec_t vecs[$];

    always #5 clk = ~clk;

    sap_1_controller_sequencer dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .LDA     (op[0]),
        .ADD     (op[1]),
        .SUB     (op[2]),
        .OUT     (op[3]),
        .HLT     (op[4]),
        .t_state (t_state),
        .con     (con),
        .halted  (halted)
    );

    task automatic check(input string nm, input logic [5:0] et, input logic [11:0] ec,
                         input logic eh);
        n_tests++;
        if (t_state !== et) begin
            n_fail++;
            $display("FAIL %s t_state got %b want %b", nm, t_state, et);
        end
        n_tests++;
        if (con !== ec) begin
            n_fail++;
            $display("FAIL %s con got %h want %h", nm, con, ec);
        end
        n_tests++;
        if (halted !== eh) begin
            n_fail++;
            $display("FAIL %s halted got %b want %b", nm, halted, eh);
        end
    endtask

    // Check mid-cycle, then advance to the next falling edge.
    task automatic step(input string nm, input logic [5:0] et, input logic [11:0] ec,
                        input logic eh);
        #1;
        check(nm, et, ec, eh);
        @(negedge clk);
    endtask

    // Queue one full instruction: op_f held during fetch, op_x during execute.
    task automatic add_instr(input string nm, input logic [4:0] op_f, input logic [4:0] op_x,
                             input logic [11:0] c4, input logic [11:0] c5,
                             input logic [11:0] c6);
        logic [11:0] cs [6];
        vec_t        v;
        cs = '{12'h5E3, 12'hBE3, 12'h263, c4, c5, c6};
        for (int i = 0; i < 6; i++) begin
            v.name = $sformatf("%s_T%0d", nm, i + 1);
            v.op   = (i < 3) ? op_f : op_x;
            v.t    = 6'b000001 << i;
            v.c    = cs[i];
            v.h    = 1'b0;
            vecs.push_back(v);
        end
    endtask

    // Asynchronous reset pulse between edges, released on a falling edge.
    task automatic do_reset(input string nm);
        op    = 5'b0;
        rst_n = 1'b0;
        #1;
        check(nm, 6'b000001, 12'h3E3, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [11:0] fetch [4];
        fetch = '{12'h5E3, 12'hBE3, 12'h263, 12'h3E3};

        add_instr("lda",    OpL,       OpL,       12'h1A3, 12'h2C3, 12'h3E3);
        add_instr("sub",    OpS,       OpS,       12'h1A3, 12'h2E1, 12'h3CF);
        add_instr("add",    OpA,       OpA,       12'h1A3, 12'h2E1, 12'h3C7);
        add_instr("out",    OpO,       OpO,       12'h3F2, 12'h3E3, 12'h3E3);
        add_instr("nop",    5'b0,      5'b0,      12'h3E3, 12'h3E3, 12'h3E3);
        add_instr("addout", OpA | OpO, OpA | OpO, 12'h3F2, 12'h3E3, 12'h3E3);
        add_instr("sublda", OpS | OpL, OpS | OpL, 12'h1A3, 12'h2E1, 12'h3CF);
        add_instr("fhlt",   OpH,       OpL,       12'h1A3, 12'h2C3, 12'h3E3);
        vecs.push_back('{name: "wrap", op: 5'b0, t: 6'b000001, c: 12'h5E3, h: 1'b0});

        // Power-on reset asserted away from any clock edge.
        op    = 5'b0;
        rst_n = 1'b1;
        #1;
        rst_n = 1'b0;
        #2;
        check("por", 6'b000001, 12'h3E3, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            op = vecs[i].op;
            step(vecs[i].name, vecs[i].t, vecs[i].c, vecs[i].h);
        end

        // HLT with LDA: halt wins, ring freezes at T4 with opcodes toggling.
        do_reset("rst_hlt");
        op = OpH | OpL;
        for (int i = 0; i < 4; i++)
            step($sformatf("hlt_T%0d", i + 1), 6'b000001 << i, fetch[i], 1'b0);
        for (int i = 0; i < 20; i++) begin
            op = 5'($urandom_range(0, 31));
            step($sformatf("halted_%0d", i), 6'b001000, 12'h3E3, 1'b1);
        end
        do_reset("rst_from_halt");
        step("post_halt_T1", 6'b000001, 12'h5E3, 1'b0);
        step("post_halt_T2", 6'b000010, 12'hBE3, 1'b0);

        // Asynchronous reset in the middle of ADD T5.
        do_reset("rst_add");
        op = OpA;
        step("add_T1", 6'b000001, 12'h5E3, 1'b0);
        step("add_T2", 6'b000010, 12'hBE3, 1'b0);
        step("add_T3", 6'b000100, 12'h263, 1'b0);
        step("add_T4", 6'b001000, 12'h1A3, 1'b0);
        #1;
        check("add_T5", 6'b010000, 12'h2E1, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check("add_T5_async_rst", 6'b000001, 12'h3E3, 1'b0);
        @(negedge clk);
        #1;
        check("rst_held", 6'b000001, 12'h3E3, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        step("after_rst_T1", 6'b000001, 12'h5E3, 1'b0);
        step("after_rst_T2", 6'b000010, 12'hBE3, 1'b0);

        // Release coincident with a rising edge: that edge must not advance.
        op    = OpL;
        rst_n = 1'b0;
        @(posedge clk);
        rst_n <= 1'b1;
        @(negedge clk);
        step("coinc_T1", 6'b000001, 12'h5E3, 1'b0);
        step("coinc_T2", 6'b000010, 12'hBE3, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
